demux_1ton_buf: RTL and testbench
=================================

Name: demux_1toN_buf

Overview:
Parametrised successor to the 1-to-8 demultiplexer. Routes a valid/ready input stream to one of N_CH output channels selected by sel. Each channel has a one-entry registered slot with its own valid/ready handshake, so a slow consumer back-pressures only beats addressed to it. Out-of-range selects are accepted and dropped with an error pulse. Sits between a single producer and N_CH independent consumers in the datapath.

Parameters:
N_CH, 8, number of output channels; legal range 2..256.
DATA_W, 1, width of each data beat in bits; at least 1.
SEL_W, $clog2(N_CH), width of sel; derived localparam, not overridable.

Ports:
clk  in  1  single clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
enable  in  1  global accept enable; when low, no new beat is accepted.
sel  in  SEL_W  destination channel for the current input beat.
din  in  DATA_W  input data beat.
in_valid  in  1  input beat present.
in_ready  out  1  block can take the beat this cycle; combinational.
douts  out  N_CH*DATA_W  channel i data at bits [i*DATA_W +: DATA_W]; registered.
out_valid  out  N_CH  channel i slot full; registered.
out_ready  in  N_CH  channel i consumer takes the beat.
drop_pulse  out  1  one-cycle pulse: a beat with an invalid sel was dropped; registered.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, douts=0, drop_pulse=0 and drop_cnt=0 (if present). Takes effect immediately. Any beats in flight are discarded with no drop_pulse.
- sel_ok = (sel < N_CH). When N_CH is a power of 2, every sel value is valid.
- in_ready = enable && (!sel_ok || !out_valid[sel] || out_ready[sel]). It depends on out_ready; it has no dependency on in_valid.
- Accept = in_valid && in_ready.
- Accept with sel_ok: slot[sel] loads din on that edge, and out_valid[sel]=1 from the next cycle. Latency is 1 cycle.
- Accept with !sel_ok: the beat is discarded, drop_pulse=1 for exactly the next cycle, and no slot changes.
- Pop on channel i: out_valid[i] && out_ready[i]. Clears out_valid[i] unless the same channel is loaded on the same edge.
- Simultaneous pop and load on the same channel: the new data replaces the old and out_valid[i] stays 1. This gives 1 beat/cycle throughput per channel.
- A full slot with out_ready low holds its data and valid indefinitely.
- While enable is low, in_ready=0, but the slots keep draining. Deasserting enable never clears slots.
- Popping does not clear the data register. douts holds the last value while out_valid=0.
- Only one channel can be loaded per cycle. Any number of channels can pop in the same cycle.
- Stimulus rule: sel and din must be known (no X/Z) whenever in_valid=1. With in_valid=0, sel/din X/Z must not change any state or output.

Optional Feature:
Macro DEMUX_DROP_CNT_EN.
- Defined: adds output port drop_cnt [15:0]. It increments on each dropped beat, saturates at 16'hFFFF and resets to 0.
- Undefined: the port is absent and only drop_pulse reports drops. All other behaviour is identical.

Decomposition:
- Package demux_pkg holds DROP_CNT_W=16 and DROP_CNT_MAX. It also holds the function clog2_min1 (returns at least 1), used to derive SEL_W for the edge cases.
- Sub-module demux_slot is one channel's register pair (data plus full flag), with inputs load, din, pop and output valid/data.
- The top level instantiates N_CH demux_slot in a generate loop, plus the in_ready logic and the drop logic.

Test Plan:
- Default params, out_ready=8'hFF, enable=1. Send din=1 with sel=0, then 2, then 7. Expect out_valid to be 8'h01, 8'h04, 8'h80 one cycle after each accept, with douts bit equal to 1. in_ready stays 1.
- Backpressure: out_ready[3]=0, then send 2 beats to sel=3. The first fills the slot; the second sees in_ready=0 and stalls. Raise out_ready[3]; the second beat loads on the same edge as the pop and out_valid[3] stays 1.
- N_CH=6, DATA_W=8: send din=8'hA5 with sel=6, then sel=7. Expect in_ready=1, drop_pulse=1 for one cycle after each, out_valid=0, and drop_cnt=2 when DEMUX_DROP_CNT_EN is defined.
- enable=0 with in_valid=1 and sel=0: expect in_ready=0 and no load. A slot already full on channel 5 drains when out_ready[5]=1. Raise enable=1 and the beat is accepted next edge.
- Hold in_valid=0 and drive sel=3'bxxx then 3'bzzz for 2 cycles each: out_valid, douts and drop_pulse do not change.
- Fill channels 1 and 4, then assert rst_n=0 mid-cycle: out_valid, douts and drop_pulse go to 0 immediately without a clock edge, and stay 0 after release until the next accept.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 1-to-N buffered demultiplexer.
//   DROP_CNT_W / DROP_CNT_MAX : width and saturation value of the optional drop counter
//   clog2_min1                : select width for a channel count, never below 1 bit
package demux_pkg;

  localparam int unsigned DROP_CNT_W = 16;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

  // Channel-select width; a 1-channel corner would otherwise yield a 0-bit port.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 32'($clog2(n));
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One output channel: a single-entry data register plus its full flag.
//   clk, rst_n : clock, async active-low reset
//   load, din  : write din into the slot and mark it full
//   pop        : consumer took the beat (clears full unless loaded on the same edge)
//   valid, data: registered slot state
module demux_slot #(
  parameter int unsigned DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Load wins over pop so a full slot can be refilled every cycle.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (pop) begin
      valid_d = 1'b0;
    end
    if (load) begin
      valid_d = 1'b1;
      data_d  = din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/demux_1ton_buf.sv
// 1-to-N_CH demultiplexer with a one-entry registered slot per channel.
// Optional macro DEMUX_DROP_CNT_EN adds a saturating 16-bit drop counter port.
//   clk, rst_n          : clock, async active-low reset
//   enable              : global accept enable
//   sel, din, in_valid  : input beat and its destination channel
//   in_ready            : combinational accept indication (independent of in_valid)
//   douts, out_valid    : per-channel registered data and full flags
//   out_ready           : per-channel consumer ready
//   drop_pulse          : one-cycle pulse after a beat with out-of-range sel is dropped
//   drop_cnt            : (DEMUX_DROP_CNT_EN only) saturating count of dropped beats
module demux_1ton_buf
  import demux_pkg::*;
#(
  parameter  int unsigned N_CH   = 8,
  parameter  int unsigned DATA_W = 1,
  localparam int unsigned SEL_W  = clog2_min1(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [SEL_W-1:0]         sel,
  input  logic [DATA_W-1:0]        din,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [N_CH*DATA_W-1:0]   douts,
  output logic [N_CH-1:0]          out_valid,
  input  logic [N_CH-1:0]          out_ready,
  output logic                     drop_pulse
`ifdef DEMUX_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0]    drop_cnt
`endif
);

  logic            sel_ok_c;
  logic            blocked_c;
  logic            accept_c;
  logic [N_CH-1:0] load_c;
  logic [N_CH-1:0] pop_c;
  logic            drop_pulse_q, drop_pulse_d;

  // Decode sel against real channels only; an out-of-range sel matches nothing,
  // so it is never blocked and is dropped on accept.
  always_comb begin
    sel_ok_c  = 1'b0;
    blocked_c = 1'b0;
    load_c    = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_ok_c  = 1'b1;
        blocked_c = out_valid[i] && !out_ready[i];
      end
    end
    in_ready = enable && !blocked_c;
    accept_c = in_valid && in_ready;
    for (int unsigned i = 0; i < N_CH; i++) begin
      load_c[i] = accept_c && (sel == SEL_W'(i));
    end
  end

  assign pop_c = out_valid & out_ready;

  // Per-channel slots.
  for (genvar g = 0; g < N_CH; g++) begin : g_slot
    demux_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load_c[g]),
      .din   (din),
      .pop   (pop_c[g]),
      .valid (out_valid[g]),
      .data  (douts[g*DATA_W +: DATA_W])
    );
  end

  // Drop indication, registered for exactly one cycle per dropped beat.
  always_comb begin
    drop_pulse_d = accept_c && !sel_ok_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_pulse_q <= 1'b0;
    end else begin
      drop_pulse_q <= drop_pulse_d;
    end
  end

  assign drop_pulse = drop_pulse_q;

`ifdef DEMUX_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of dropped beats.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_pulse_d && (drop_cnt_q != DROP_CNT_MAX)) begin
      drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_demux_1ton_buf.sv
// Self-checking bench: two instances (8 x 1-bit and 6 x 8-bit) share one stimulus
// stream and are compared against a per-instance array/queue-style reference model.
module tb_demux_1ton_buf;

`ifdef DEMUX_DROP_CNT_EN
  localparam int unsigned CNT_W = 16;
`else
  localparam int unsigned CNT_W = 0;
`endif
  localparam int unsigned SNAP_A_W = 8 + 8 + 1 + CNT_W;
  localparam int unsigned SNAP_B_W = 8 + 48 + 1 + CNT_W;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        in_valid;
  logic [2:0]  sel;
  logic [7:0]  din;
  logic [7:0]  out_ready;

  logic        in_ready_a, in_ready_b;
  logic        drop_a, drop_b;
  logic [7:0]  ov_a, dout_a;
  logic [5:0]  ov_b;
  logic [47:0] dout_b;
`ifdef DEMUX_DROP_CNT_EN
  logic [15:0] cnt_a, cnt_b;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  demux_1ton_buf #(.N_CH(8), .DATA_W(1)) u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .sel        (sel),
    .din        (din[0:0]),
    .in_valid   (in_valid),
    .in_ready   (in_ready_a),
    .douts      (dout_a),
    .out_valid  (ov_a),
    .out_ready  (out_ready),
    .drop_pulse (drop_a)
`ifdef DEMUX_DROP_CNT_EN
    ,
    .drop_cnt   (cnt_a)
`endif
  );

  demux_1ton_buf #(.N_CH(6), .DATA_W(8)) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .sel        (sel),
    .din        (din),
    .in_valid   (in_valid),
    .in_ready   (in_ready_b),
    .douts      (dout_b),
    .out_valid  (ov_b),
    .out_ready  (out_ready[5:0]),
    .drop_pulse (drop_b)
`ifdef DEMUX_DROP_CNT_EN
    ,
    .drop_cnt   (cnt_b)
`endif
  );

  // ---------------- reference model (index 0 = 8x1, index 1 = 6x8) ----------------
  bit          m_valid [2][8];
  logic [7:0]  m_data  [2][8];
  bit          m_drop  [2];
  int unsigned m_cnt   [2];
  int unsigned nch     [2] = '{8, 6};
  logic [7:0]  dmask   [2] = '{8'h01, 8'hFF};

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) begin
        m_valid[k][i] = 1'b0;
        m_data[k][i]  = 8'h00;
      end
      m_drop[k] = 1'b0;
      m_cnt[k]  = 0;
    end
  endtask

  // Ready unless the addressed, existing channel is full and its consumer stalls.
  function automatic bit exp_ready(input int k);
    int s;
    s = int'(sel);
    if (enable !== 1'b1) return 1'b0;
    if (s >= int'(nch[k])) return 1'b1;
    return !(m_valid[k][s] && (out_ready[s] !== 1'b1));
  endfunction

  // One clock edge of the behavioural model, using the inputs present at that edge.
  task automatic model_clock();
    for (int k = 0; k < 2; k++) begin
      bit acc;
      int s;
      acc = (in_valid === 1'b1) ? exp_ready(k) : 1'b0;
      for (int i = 0; i < int'(nch[k]); i++) begin
        if (m_valid[k][i] && out_ready[i] === 1'b1) m_valid[k][i] = 1'b0;
      end
      m_drop[k] = 1'b0;
      if (acc) begin
        s = int'(sel);
        if (s < int'(nch[k])) begin
          m_valid[k][s] = 1'b1;
          m_data[k][s]  = din & dmask[k];
        end else begin
          m_drop[k] = 1'b1;
          if (m_cnt[k] < 65535) m_cnt[k]++;
        end
      end
    end
  endtask

  function automatic logic [7:0] exp_ov(input int k);
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < int'(nch[k]); i++) v[i] = m_valid[k][i];
    return v;
  endfunction

  function automatic logic [SNAP_A_W-1:0] exp_snap_a();
    logic [7:0] d;
    for (int i = 0; i < 8; i++) d[i] = m_data[0][i][0];
`ifdef DEMUX_DROP_CNT_EN
    return {exp_ov(0), d, m_drop[0], 16'(m_cnt[0])};
`else
    return {exp_ov(0), d, m_drop[0]};
`endif
  endfunction

  function automatic logic [SNAP_B_W-1:0] exp_snap_b();
    logic [47:0] d;
    for (int i = 0; i < 6; i++) d[i*8 +: 8] = m_data[1][i];
`ifdef DEMUX_DROP_CNT_EN
    return {exp_ov(1), d, m_drop[1], 16'(m_cnt[1])};
`else
    return {exp_ov(1), d, m_drop[1]};
`endif
  endfunction

  function automatic logic [SNAP_A_W-1:0] act_snap_a();
`ifdef DEMUX_DROP_CNT_EN
    return {ov_a, dout_a, drop_a, cnt_a};
`else
    return {ov_a, dout_a, drop_a};
`endif
  endfunction

  function automatic logic [SNAP_B_W-1:0] act_snap_b();
`ifdef DEMUX_DROP_CNT_EN
    return {2'b00, ov_b, dout_b, drop_b, cnt_b};
`else
    return {2'b00, ov_b, dout_b, drop_b};
`endif
  endfunction

  // Advance one clock; leaves time 1 unit after the rising edge.
  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; in_valid = 1'b0; sel = '0; din = '0; out_ready = 8'hFF;
    model_reset();
    #3;
    n_checks++;
    if (act_snap_a() !== exp_snap_a()) begin
      n_fail++; $display("FAIL reset_a: got %h expected %h", act_snap_a(), exp_snap_a());
    end
    n_checks++;
    if (act_snap_b() !== exp_snap_b()) begin
      n_fail++; $display("FAIL reset_b: got %h expected %h", act_snap_b(), exp_snap_b());
    end
    #4 rst_n = 1'b1;
    step();
  endtask

  task automatic test_route();
    logic [2:0] sels [3] = '{3'd0, 3'd2, 3'd7};
    enable = 1'b1; out_ready = 8'hFF;
    foreach (sels[j]) begin
      in_valid = 1'b1; sel = sels[j]; din = 8'h01;
      #1;
      n_checks++;
      if (in_ready_a !== 1'b1) begin
        n_fail++; $display("FAIL route_in_ready sel=%0d: got %b expected 1", sel, in_ready_a);
      end
      step();
      n_checks++;
      if (ov_a !== (8'h01 << sels[j]) || dout_a[sels[j]] !== 1'b1) begin
        n_fail++; $display("FAIL route_a sel=%0d: got valid %h data %h expected valid %h data bit 1",
                           sels[j], ov_a, dout_a, 8'h01 << sels[j]);
      end
      n_checks++;
      if (act_snap_b() !== exp_snap_b()) begin
        n_fail++; $display("FAIL route_b sel=%0d: got %h expected %h", sels[j], act_snap_b(), exp_snap_b());
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    enable = 1'b1; out_ready = 8'hF7; in_valid = 1'b1; sel = 3'd3; din = 8'h3C;
    #1;
    n_checks++;
    if (in_ready_a !== 1'b1) begin
      n_fail++; $display("FAIL bp_first_ready: got %b expected 1", in_ready_a);
    end
    step();
    din = 8'hC3;
    #1;
    n_checks++;
    if (in_ready_a !== 1'b0 || in_ready_b !== 1'b0) begin
      n_fail++; $display("FAIL bp_stall_ready: got a=%b b=%b expected 0 0", in_ready_a, in_ready_b);
    end
    step();
    n_checks++;
    if (act_snap_b() !== exp_snap_b() || dout_b[31:24] !== 8'h3C) begin
      n_fail++; $display("FAIL bp_hold_b: got %h expected %h", act_snap_b(), exp_snap_b());
    end
    out_ready = 8'hFF;
    #1;
    n_checks++;
    if (in_ready_a !== 1'b1) begin
      n_fail++; $display("FAIL bp_release_ready: got %b expected 1", in_ready_a);
    end
    step();
    n_checks++;
    if (ov_a[3] !== 1'b1 || dout_a[3] !== 1'b1 || ov_b[3] !== 1'b1 || dout_b[31:24] !== 8'hC3) begin
      n_fail++; $display("FAIL bp_refill: got va=%b da=%b vb=%b db=%h expected 1 1 1 c3",
                         ov_a[3], dout_a[3], ov_b[3], dout_b[31:24]);
    end
    n_checks++;
    if (act_snap_a() !== exp_snap_a()) begin
      n_fail++; $display("FAIL bp_snap_a: got %h expected %h", act_snap_a(), exp_snap_a());
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_drop();
    logic [2:0] sels [2] = '{3'd6, 3'd7};
`ifdef DEMUX_DROP_CNT_EN
    logic [15:0] cnt0;
    cnt0 = cnt_b;
`endif
    enable = 1'b1; out_ready = 8'hFF; in_valid = 1'b0;
    step();
    foreach (sels[j]) begin
      in_valid = 1'b1; sel = sels[j]; din = 8'hA5;
      #1;
      n_checks++;
      if (in_ready_b !== 1'b1) begin
        n_fail++; $display("FAIL drop_in_ready sel=%0d: got %b expected 1", sel, in_ready_b);
      end
      step();
      n_checks++;
      if (drop_b !== 1'b1 || ov_b !== 6'h00 || act_snap_b() !== exp_snap_b()) begin
        n_fail++; $display("FAIL drop_b sel=%0d: got %h expected %h", sels[j], act_snap_b(), exp_snap_b());
      end
    end
    in_valid = 1'b0;
    step();
    n_checks++;
    if (drop_b !== 1'b0 || drop_a !== 1'b0) begin
      n_fail++; $display("FAIL drop_pulse_width: got a=%b b=%b expected 0 0", drop_a, drop_b);
    end
`ifdef DEMUX_DROP_CNT_EN
    n_checks++;
    if (cnt_b !== cnt0 + 16'd2) begin
      n_fail++; $display("FAIL drop_cnt: got %0d expected %0d", cnt_b, cnt0 + 16'd2);
    end
`endif
  endtask

  task automatic test_enable();
    enable = 1'b1; out_ready = 8'h00; in_valid = 1'b1; sel = 3'd5; din = 8'h22;
    step();
    enable = 1'b0; sel = 3'd0; din = 8'h11; out_ready = 8'h20;
    #1;
    n_checks++;
    if (in_ready_a !== 1'b0 || in_ready_b !== 1'b0) begin
      n_fail++; $display("FAIL en_low_ready: got a=%b b=%b expected 0 0", in_ready_a, in_ready_b);
    end
    step();
    n_checks++;
    if (ov_a[0] !== 1'b0 || ov_a[5] !== 1'b0 || act_snap_b() !== exp_snap_b()) begin
      n_fail++; $display("FAIL en_low_drain: got va=%h snap_b=%h expected va bits0/5 clear, %h",
                         ov_a, act_snap_b(), exp_snap_b());
    end
    enable = 1'b1;
    #1;
    n_checks++;
    if (in_ready_a !== 1'b1) begin
      n_fail++; $display("FAIL en_high_ready: got %b expected 1", in_ready_a);
    end
    step();
    n_checks++;
    if (ov_b[0] !== 1'b1 || dout_b[7:0] !== 8'h11 || act_snap_a() !== exp_snap_a()) begin
      n_fail++; $display("FAIL en_high_load: got vb=%h db0=%h snap_a=%h expected ch0 11, %h",
                         ov_b, dout_b[7:0], act_snap_a(), exp_snap_a());
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_xz_idle();
    logic [SNAP_A_W-1:0] held_a;
    logic [SNAP_B_W-1:0] held_b;
    enable = 1'b1; out_ready = 8'h00; in_valid = 1'b1; sel = 3'd3; din = 8'h5B;
    step();
    in_valid = 1'b0;
    held_a = exp_snap_a();
    held_b = exp_snap_b();
    for (int c = 0; c < 4; c++) begin
      sel = (c < 2) ? 3'bxxx : 3'bzzz;
      din = (c < 2) ? 8'hxx : 8'hzz;
      step();
      n_checks++;
      if (act_snap_a() !== held_a || act_snap_a() !== exp_snap_a()) begin
        n_fail++; $display("FAIL xz_a cyc=%0d: got %h expected %h", c, act_snap_a(), held_a);
      end
      n_checks++;
      if (act_snap_b() !== held_b) begin
        n_fail++; $display("FAIL xz_b cyc=%0d: got %h expected %h", c, act_snap_b(), held_b);
      end
    end
    sel = '0; din = '0;
  endtask

  task automatic test_async_reset();
    enable = 1'b1; out_ready = 8'h00; in_valid = 1'b1;
    sel = 3'd1; din = 8'hFF;
    step();
    sel = 3'd4; din = 8'h81;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (ov_a[1] !== 1'b1 || ov_a[4] !== 1'b1 || act_snap_b() !== exp_snap_b()) begin
      n_fail++; $display("FAIL ar_fill: got va=%h snap_b=%h expected %h", ov_a, act_snap_b(), exp_snap_b());
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (ov_a !== 8'h00 || dout_a !== 8'h00 || drop_a !== 1'b0) begin
      n_fail++; $display("FAIL ar_immediate_a: got v=%h d=%h p=%b expected 0", ov_a, dout_a, drop_a);
    end
    n_checks++;
    if (act_snap_b() !== exp_snap_b()) begin
      n_fail++; $display("FAIL ar_immediate_b: got %h expected %h", act_snap_b(), exp_snap_b());
    end
    step();
    rst_n = 1'b1;
    out_ready = 8'hFF;
    step();
    step();
    n_checks++;
    if (act_snap_a() !== exp_snap_a() || act_snap_b() !== exp_snap_b()) begin
      n_fail++; $display("FAIL ar_after_release: got a=%h b=%h expected a=%h b=%h",
                         act_snap_a(), act_snap_b(), exp_snap_a(), exp_snap_b());
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      enable    = ($urandom_range(0, 7) != 0);
      in_valid  = 1'($urandom_range(0, 1));
      sel       = 3'($urandom_range(0, 7));
      din       = 8'($urandom);
      out_ready = 8'($urandom) | 8'($urandom);
      #1;
      n_checks++;
      if (in_ready_a !== exp_ready(0) || in_ready_b !== exp_ready(1)) begin
        n_fail++; $display("FAIL rand_ready cyc=%0d: got a=%b b=%b expected a=%b b=%b",
                           c, in_ready_a, in_ready_b, exp_ready(0), exp_ready(1));
      end
      step();
      n_checks++;
      if (act_snap_a() !== exp_snap_a()) begin
        n_fail++; $display("FAIL rand_a cyc=%0d: got %h expected %h", c, act_snap_a(), exp_snap_a());
      end
      n_checks++;
      if (act_snap_b() !== exp_snap_b()) begin
        n_fail++; $display("FAIL rand_b cyc=%0d: got %h expected %h", c, act_snap_b(), exp_snap_b());
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_route();
    test_backpressure();
    test_drop();
    test_enable();
    test_xz_idle();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
